regfile_sb: RTL and testbench

Parametrised register file with byte-lane writes, optional half-swap on write, registered dual read ports and a per-register pending-write scoreboard. It is the next-generation register file for the Minx16-family cores. It is generalised in data width and depth and adds a lock/clear scoreboard so the issue stage can stall on long-latency results such as loads. It sits between decode (read ports, lock port) and writeback (write port).

---
 rtl/regfile_sb.sv | 114 +++++++++++
 tb/tb_regfile_sb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with byte-lane merge, optional half-swap on write,
// registered dual read ports and a lock/clear pending scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding in the same edge).
module regfile_sb #(
  parameter int unsigned A       = 3,
  parameter int unsigned W       = 16,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                re_i,
  input  logic [A-1:0]        ra_i,
  input  logic [A-1:0]        rb_i,
  output logic [W-1:0]        da_o,
  output logic [W-1:0]        db_o,
  output logic                a_busy_o,
  output logic                b_busy_o,
  input  logic                we_i,
  input  logic [A-1:0]        rd_i,
  input  logic [W-1:0]        dd_i,
  input  logic [W/8-1:0]      be_i,
  input  logic                sw_i,
  input  logic                lk_i,
  input  logic [A-1:0]        lk_rd_i,
  output logic                lk_err_o,
  output logic [(2**A)-1:0]   pend_o
);

  localparam int unsigned N  = 2**A;
  localparam int unsigned L  = W/8;
  localparam int unsigned H  = W/2;
  localparam bit          ZR = (ZERO_R0 != 0);

  logic [W-1:0] file_q [N];
  logic [W-1:0] da_q, da_d;
  logic [W-1:0] db_q, db_d;
  logic [N-1:0] pend_q, pend_d;
  logic         lk_err_q, lk_err_d;

  logic [W-1:0] merged_c;
  logic [W-1:0] stored_c;
  logic         wr_en_c;
  logic         lk_en_c;
  logic         byp_a_c;
  logic         byp_b_c;

  // Writes and locks aimed at a hard-wired r0 are dropped here.
  assign wr_en_c = we_i && !(ZR && (rd_i == '0));
  assign lk_en_c = lk_i && !(ZR && (lk_rd_i == '0));

  // Byte-lane merge against the current contents, then optional half swap.
  always_comb begin : merge
    merged_c = file_q[rd_i];
    for (int unsigned i = 0; i < L; i++) begin
      if (be_i[i]) merged_c[8*i +: 8] = dd_i[8*i +: 8];
    end
    stored_c = sw_i ? {merged_c[H-1:0], merged_c[W-1:H]} : merged_c;
  end

`ifdef REGFILE_BYPASS_EN
  assign byp_a_c = re_i && we_i && (ra_i == rd_i);
  assign byp_b_c = re_i && we_i && (rb_i == rd_i);
`else
  assign byp_a_c = 1'b0;
  assign byp_b_c = 1'b0;
`endif

  always_comb begin : next_state
    pend_d   = pend_q;
    lk_err_d = 1'b0;
    da_d     = da_q;
    db_d     = db_q;

    // Clear on write first so a same-cycle lock to the same register wins.
    if (we_i)    pend_d[rd_i]    = 1'b0;
    if (lk_en_c) pend_d[lk_rd_i] = 1'b1;
    if (ZR)      pend_d[0]       = 1'b0;

    lk_err_d = lk_en_c && pend_q[lk_rd_i] && !(we_i && (rd_i == lk_rd_i));

    if (re_i) begin
      da_d = (byp_a_c && wr_en_c) ? stored_c : file_q[ra_i];
      db_d = (byp_b_c && wr_en_c) ? stored_c : file_q[rb_i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < N; i++) begin
        file_q[i] <= '0;
      end
      da_q     <= '0;
      db_q     <= '0;
      pend_q   <= '0;
      lk_err_q <= 1'b0;
    end else begin
      if (wr_en_c) file_q[rd_i] <= stored_c;
      da_q     <= da_d;
      db_q     <= db_d;
      pend_q   <= pend_d;
      lk_err_q <= lk_err_d;
    end
  end

  // Busy flags follow the registered scoreboard; a forwarded read is never busy.
  assign a_busy_o = pend_q[ra_i] && !byp_a_c;
  assign b_busy_o = pend_q[rb_i] && !byp_b_c;

  assign da_o     = da_q;
  assign db_o     = db_q;
  assign lk_err_o = lk_err_q;
  assign pend_o   = pend_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb; read data goes through a scoreboard
// queue, status outputs are compared inline. Two instances: ZERO_R0 = 0 and 1.
module tb_regfile_sb;

  localparam int unsigned A = 3;
  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] za;
    logic [W-1:0] zb;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           re;
  logic [A-1:0]   ra, rb;
  logic           we;
  logic [A-1:0]   rd;
  logic [W-1:0]   dd;
  logic [W/8-1:0] be;
  logic           sw;
  logic           lk;
  logic [A-1:0]   lk_rd;

  logic [W-1:0]   da, db, da_z, db_z;
  logic           a_busy, b_busy, a_busy_z, b_busy_z;
  logic           lk_err, lk_err_z;
  logic [7:0]     pend, pend_z;

  int   errors = 0;
  int   checks = 0;
  logic rvalid;
  exp_t sb_q[$];

  regfile_sb #(.A(A), .W(W), .ZERO_R0(0)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .re_i(re), .ra_i(ra), .rb_i(rb),
    .da_o(da), .db_o(db), .a_busy_o(a_busy), .b_busy_o(b_busy),
    .we_i(we), .rd_i(rd), .dd_i(dd), .be_i(be), .sw_i(sw),
    .lk_i(lk), .lk_rd_i(lk_rd), .lk_err_o(lk_err), .pend_o(pend)
  );

  regfile_sb #(.A(A), .W(W), .ZERO_R0(1)) u_dut_z (
    .clk_i(clk), .rst_ni(rst_n), .re_i(re), .ra_i(ra), .rb_i(rb),
    .da_o(da_z), .db_o(db_z), .a_busy_o(a_busy_z), .b_busy_o(b_busy_z),
    .we_i(we), .rd_i(rd), .dd_i(dd), .be_i(be), .sw_i(sw),
    .lk_i(lk), .lk_rd_i(lk_rd), .lk_err_o(lk_err_z), .pend_o(pend_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // A read issued before an edge presents its data after that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rvalid <= 1'b0;
    else        rvalid <= re;
  end

  always @(negedge clk) begin
    if (rvalid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow: got read data %h with no expected entry", da);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("rd_da",   32'(da),   32'(e.a));
        check("rd_db",   32'(db),   32'(e.b));
        check("rd_da_z", 32'(da_z), 32'(e.za));
        check("rd_db_z", 32'(db_z), 32'(e.zb));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; lk = 1'b0; re = 1'b0; be = '0; sw = 1'b0;
  endtask

  task automatic push_exp(input logic [A-1:0] a_adr, input logic [A-1:0] b_adr,
                          input logic [W-1:0] ea, input logic [W-1:0] eb);
    exp_t e;
    e.a  = ea;
    e.b  = eb;
    e.za = (a_adr == '0) ? '0 : ea;
    e.zb = (b_adr == '0) ? '0 : eb;
    sb_q.push_back(e);
  endtask

  task automatic do_read(input logic [A-1:0] a_adr, input logic [A-1:0] b_adr,
                         input logic [W-1:0] ea, input logic [W-1:0] eb);
    ra = a_adr; rb = b_adr; re = 1'b1;
    push_exp(a_adr, b_adr, ea, eb);
    cyc();
    re = 1'b0;
  endtask

  task automatic do_write(input logic [A-1:0] r, input logic [W-1:0] d,
                          input logic [W/8-1:0] b, input logic s);
    we = 1'b1; rd = r; dd = d; be = b; sw = s;
    cyc();
    we = 1'b0; be = '0; sw = 1'b0;
  endtask

  task automatic do_lock(input logic [A-1:0] r);
    lk = 1'b1; lk_rd = r;
    cyc();
    lk = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    idle();
    ra = '0; rb = '0; rd = '0; dd = '0; lk_rd = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_da",     32'(da),     32'h0);
    check("rst_db",     32'(db),     32'h0);
    check("rst_pend",   32'(pend),   32'h0);
    check("rst_lk_err", 32'(lk_err), 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;

    // Mid-stream reset after r3 = BEEF and a lock on r1.
    we = 1'b1; rd = 3'd3; dd = 16'hBEEF; be = 2'b11; lk = 1'b1; lk_rd = 3'd1;
    cyc();
    idle();
    check("pre_rst_pend", 32'(pend), 32'h02);
    do_read(3'd3, 3'd3, 16'hBEEF, 16'hBEEF);
    cyc();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_da",   32'(da),   32'h0);
    check("mid_rst_db",   32'(db),   32'h0);
    check("mid_rst_pend", 32'(pend), 32'h0);
    cyc();
    rst_n = 1'b1;
    do_read(3'd3, 3'd3, 16'h0000, 16'h0000);

    // Byte merge.
    do_write(3'd2, 16'h1234, 2'b11, 1'b0);
    do_write(3'd2, 16'hAB77, 2'b01, 1'b0);
    do_read(3'd2, 3'd2, 16'h1277, 16'h1277);

    // Swap in place, then merge-and-swap.
    do_write(3'd2, 16'hFFFF, 2'b00, 1'b1);
    do_read(3'd2, 3'd3, 16'h7712, 16'h0000);
    do_write(3'd2, 16'hCD00, 2'b10, 1'b1);
    do_read(3'd2, 3'd2, 16'h12CD, 16'h12CD);

    // be = 0, sw = 0: data unchanged but still clears the pending bit.
    do_lock(3'd2);
    check("lock2_pend",   32'(pend),   32'h04);
    check("lock2_lk_err", 32'(lk_err), 32'h0);
    do_write(3'd2, 16'h0000, 2'b00, 1'b0);
    check("nop_wr_pend", 32'(pend), 32'h00);
    do_read(3'd2, 3'd2, 16'h12CD, 16'h12CD);

    // Scoreboard: lock, relock, write+lock, write alone.
    do_lock(3'd5);
    ra = 3'd5;
    #1;
    check("lock5_pend",   32'(pend),   32'h20);
    check("lock5_a_busy", 32'(a_busy), 32'h1);
    check("lock5_lk_err", 32'(lk_err), 32'h0);
    do_lock(3'd5);
    check("relock5_lk_err", 32'(lk_err), 32'h1);
    check("relock5_pend",   32'(pend),   32'h20);
    we = 1'b1; rd = 3'd5; dd = 16'h0042; be = 2'b11; lk = 1'b1; lk_rd = 3'd5;
    cyc();
    idle();
    check("wrlk5_pend",   32'(pend),   32'h20);
    check("wrlk5_lk_err", 32'(lk_err), 32'h0);
    do_read(3'd5, 3'd5, 16'h0042, 16'h0042);
    do_write(3'd5, 16'h0000, 2'b00, 1'b0);
    check("clr5_pend",   32'(pend),   32'h00);
    check("clr5_a_busy", 32'(a_busy), 32'h0);

    // Same-cycle read of a register being written.
    we = 1'b1; rd = 3'd4; dd = 16'h0001; be = 2'b11; lk = 1'b1; lk_rd = 3'd4;
    cyc();
    idle();
    check("lock4_pend", 32'(pend), 32'h10);
    we = 1'b1; rd = 3'd4; dd = 16'h5A5A; be = 2'b11;
    re = 1'b1; ra = 3'd4; rb = 3'd2;
`ifdef REGFILE_BYPASS_EN
    push_exp(3'd4, 3'd2, 16'h5A5A, 16'h12CD);
    #1 check("byp_a_busy", 32'(a_busy), 32'h0);
`else
    push_exp(3'd4, 3'd2, 16'h0001, 16'h12CD);
    #1 check("byp_a_busy", 32'(a_busy), 32'h1);
`endif
    check("byp_b_busy", 32'(b_busy), 32'h0);
    cyc();
    idle();
    check("byp_pend", 32'(pend), 32'h00);
    do_read(3'd4, 3'd4, 16'h5A5A, 16'h5A5A);
    do_read(3'd2, 3'd4, 16'h12CD, 16'h5A5A);

    // r0 handling: normal on u_dut, hard-wired zero on u_dut_z.
    we = 1'b1; rd = 3'd0; dd = 16'hFFFF; be = 2'b11; lk = 1'b1; lk_rd = 3'd0;
    cyc();
    idle();
    check("r0_pend",   32'(pend),   32'h01);
    check("r0_pend_z", 32'(pend_z), 32'h00);
    do_lock(3'd0);
    check("r0_lk_err",   32'(lk_err),   32'h1);
    check("r0_lk_err_z", 32'(lk_err_z), 32'h0);
    check("r0_pend_z2",  32'(pend_z),   32'h00);
    do_read(3'd0, 3'd0, 16'hFFFF, 16'hFFFF);
    check("r0_a_busy",   32'(a_busy),   32'h1);
    check("r0_a_busy_z", 32'(a_busy_z), 32'h0);
    check("r0_b_busy_z", 32'(b_busy_z), 32'h0);

    cyc();
    cyc();
    check("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
